// File: rtl/demux4_dispatch_if.sv
// Handshake bundle for demux4_dispatch: one producer-side word stream in,
// four consumer channels out, plus round-robin and transfer-count status.
interface demux4_dispatch_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             rr_mode;
  logic             in_ready;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [3:0]       out_ready;
  logic [1:0]       rr_ptr;
  logic [15:0]      xfer_count;

  modport master (
    output in_valid, in_data, in_sel, rr_mode, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           rr_ptr, xfer_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, rr_mode, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           rr_ptr, xfer_count
  );
endinterface

// File: rtl/demux4_dispatch.sv
// One-to-four dispatcher: each accepted word lands in a single-entry holding
// register of the channel chosen by in_sel or by the round-robin pointer.
module demux4_dispatch #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  demux4_dispatch_if.slave  bus
);

  logic [3:0]       out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]      xfer_count_q, xfer_count_d;

  logic [1:0] target;
  logic       accept;

  // A full channel that is draining this cycle can still take a new word.
  assign target       = bus.rr_mode ? rr_ptr_q : bus.in_sel;
  assign bus.in_ready = ~out_valid_q[target] | bus.out_ready[target];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    out_valid_d  = out_valid_q & ~bus.out_ready;
    data_d       = data_q;
    rr_ptr_d     = rr_ptr_q;
    xfer_count_d = xfer_count_q;
    if (accept) begin
      out_valid_d[target] = 1'b1;
      data_d[target]      = bus.in_data;
      xfer_count_d        = xfer_count_q + 16'd1;
      if (bus.rr_mode) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= '0;
      data_q       <= '{default: '0};
      rr_ptr_q     <= '0;
      xfer_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      rr_ptr_q     <= rr_ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data0  = data_q[0];
  assign bus.out_data1  = data_q[1];
  assign bus.out_data2  = data_q[2];
  assign bus.out_data3  = data_q[3];
  assign bus.rr_ptr     = rr_ptr_q;
  assign bus.xfer_count = xfer_count_q;

endmodule
